// File: rtl/draw_pkg.sv
// Shared drawing definitions: screen geometry defaults, colour constants,
// framebuffer address width helper and the pixel write entry type.
package draw_pkg;

  localparam int SCREEN_WIDTH_DEF  = 640;
  localparam int SCREEN_HEIGHT_DEF = 480;
  localparam int COLOUR_W          = 3;

  localparam logic [COLOUR_W-1:0] COL_BLACK = 3'b000;
  localparam logic [COLOUR_W-1:0] COL_WHITE = 3'b111;

  function automatic int addr_w(input int width, input int height);
    return $clog2(width * height);
  endfunction

  localparam int ADDR_W_DEF = addr_w(SCREEN_WIDTH_DEF, SCREEN_HEIGHT_DEF);

  typedef struct packed {
    logic [ADDR_W_DEF-1:0] addr;
    logic [COLOUR_W-1:0]   colour;
  } pix_wr_t;

endpackage

// File: rtl/plot_fifo.sv
// Synchronous write-buffer FIFO; a push is accepted when full only if a pop
// happens on the same edge. DEPTH must be a power of two.
module plot_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             iClk,
  input  logic             iResetn,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] head_data
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             push_ok, pop_ok;

  assign full      = (count_q == CNT_W'(DEPTH));
  assign empty     = (count_q == '0);
  assign head_data = mem_q[rd_ptr_q];

  always_comb begin
    pop_ok   = pop && !empty;
    push_ok  = push && (!full || pop_ok);
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) begin
      mem_d[wr_ptr_q] = push_data;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (pop_ok) rd_ptr_d = rd_ptr_q + 1'b1;
    if (push_ok && !pop_ok)      count_d = count_q + 1'b1;
    else if (!push_ok && pop_ok) count_d = count_q - 1'b1;
  end

  // Storage is cleared on reset so the head reads zero out of reset.
  always_ff @(posedge iClk or negedge iResetn) begin
    if (!iResetn) begin
      mem_q    <= '{default: '0};
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/plot_sink_writer.sv
// Pixel-plot sink: capture, clip, linear address, buffered framebuffer writes.
// Optional transfer/drop counters are built when PLOT_SINK_STATS_EN is defined.
module plot_sink_writer
  import draw_pkg::*;
#(
  parameter int SCREEN_WIDTH  = SCREEN_WIDTH_DEF,
  parameter int SCREEN_HEIGHT = SCREEN_HEIGHT_DEF,
  parameter int COL_W         = COLOUR_W,
  parameter int FIFO_DEPTH    = 4,
  localparam int ADDR_W       = addr_w(SCREEN_WIDTH, SCREEN_HEIGHT),
  localparam int X_W          = $clog2(SCREEN_WIDTH) + 1,
  localparam int Y_W          = $clog2(SCREEN_HEIGHT) + 1
) (
  input  logic              iClk,
  input  logic              iResetn,
  input  logic [X_W-1:0]    iX_pixel,
  input  logic [Y_W-1:0]    iY_pixel,
  input  logic [COL_W-1:0]  iColour,
  input  logic              iPlot,
  input  logic              iMemGrant,
  input  logic              iClearErr,
  output logic [ADDR_W-1:0] oMemAddr,
  output logic [COL_W-1:0]  oMemData,
  output logic              oMemWe,
  output logic              oBusy,
  output logic              oClipped,
  output logic              oOverflow
`ifdef PLOT_SINK_STATS_EN
  ,
  output logic [31:0]       oWriteCount,
  output logic [15:0]       oDropCount
`endif
);

  localparam logic [X_W-1:0] X_LIM = X_W'(SCREEN_WIDTH);
  localparam logic [Y_W-1:0] Y_LIM = Y_W'(SCREEN_HEIGHT);
  localparam int ENTRY_W = ADDR_W + COL_W;

  logic              s1_valid_q, s1_valid_d;
  logic [X_W-1:0]    s1_x_q, s1_x_d;
  logic [Y_W-1:0]    s1_y_q, s1_y_d;
  logic [COL_W-1:0]  s1_col_q, s1_col_d;
  logic              s2_valid_q, s2_valid_d;
  logic [ADDR_W-1:0] s2_addr_q, s2_addr_d;
  logic [COL_W-1:0]  s2_col_q, s2_col_d;
  logic              clip_q, clip_d;
  logic              overflow_q, overflow_d;

  logic               fifo_full, fifo_empty, pop, drop_evt;
  logic [ENTRY_W-1:0] head;

  always_comb begin
    s1_valid_d = iPlot;
    s1_x_d     = iX_pixel;
    s1_y_d     = iY_pixel;
    s1_col_d   = iColour;

    clip_d     = s1_valid_q && ((s1_x_q >= X_LIM) || (s1_y_q >= Y_LIM));
    s2_valid_d = s1_valid_q && !clip_d;
    // Widen both operands first so y*width never truncates before the add.
    s2_addr_d  = ADDR_W'(s1_y_q) * ADDR_W'(SCREEN_WIDTH) + ADDR_W'(s1_x_q);
    s2_col_d   = s1_col_q;

    pop        = !fifo_empty && iMemGrant;
    drop_evt   = s2_valid_q && fifo_full && !pop;
    overflow_d = drop_evt || (overflow_q && !iClearErr);
  end

  always_ff @(posedge iClk or negedge iResetn) begin
    if (!iResetn) begin
      s1_valid_q <= 1'b0;
      s1_x_q     <= '0;
      s1_y_q     <= '0;
      s1_col_q   <= '0;
      s2_valid_q <= 1'b0;
      s2_addr_q  <= '0;
      s2_col_q   <= '0;
      clip_q     <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_x_q     <= s1_x_d;
      s1_y_q     <= s1_y_d;
      s1_col_q   <= s1_col_d;
      s2_valid_q <= s2_valid_d;
      s2_addr_q  <= s2_addr_d;
      s2_col_q   <= s2_col_d;
      clip_q     <= clip_d;
      overflow_q <= overflow_d;
    end
  end

  plot_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .iClk      (iClk),
    .iResetn   (iResetn),
    .push      (s2_valid_q),
    .push_data ({s2_addr_q, s2_col_q}),
    .pop       (pop),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .head_data (head)
  );

  assign oMemAddr  = head[ENTRY_W-1:COL_W];
  assign oMemData  = head[COL_W-1:0];
  assign oMemWe    = !fifo_empty;
  assign oBusy     = s1_valid_q || s2_valid_q || !fifo_empty;
  assign oClipped  = clip_q;
  assign oOverflow = overflow_q;

`ifdef PLOT_SINK_STATS_EN
  logic [31:0] wr_cnt_q, wr_cnt_d;
  logic [15:0] drop_cnt_q, drop_cnt_d;
  logic [16:0] drop_sum;

  // A clip and an overflow drop can land on the same edge, hence +2.
  always_comb begin
    drop_sum   = {1'b0, drop_cnt_q} + 17'(clip_d) + 17'(drop_evt);
    drop_cnt_d = drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
    wr_cnt_d   = wr_cnt_q + 32'(pop);
    if (iClearErr) begin
      drop_cnt_d = '0;
      wr_cnt_d   = '0;
    end
  end

  always_ff @(posedge iClk or negedge iResetn) begin
    if (!iResetn) begin
      wr_cnt_q   <= '0;
      drop_cnt_q <= '0;
    end else begin
      wr_cnt_q   <= wr_cnt_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  assign oWriteCount = wr_cnt_q;
  assign oDropCount  = drop_cnt_q;
`endif

endmodule

// File: doc/plot_sink_writer.md
Name: plot_sink_writer

Overview:
- Receiving end of the pixel-plot stream (x, y, colour, plot strobe) that the drawing datapath drives.
- Clips out-of-screen coordinates and converts each accepted (x, y) to a linear framebuffer address, y*SCREEN_WIDTH + x.
- Buffers writes in a small FIFO so the framebuffer write port can stall via a grant signal.
- Sits between the drawing datapath and the framebuffer memory arbiter. The producer has no backpressure, so the block buffers, and drops and flags on overflow.

Parameters:
- SCREEN_WIDTH, 640, visible pixels per line.
- SCREEN_HEIGHT, 480, visible lines.
- COLOUR_W, 3, colour bits per pixel.
- FIFO_DEPTH, 4, write-buffer entries; power of two, ≥2.
- ADDR_W, $clog2(SCREEN_WIDTH*SCREEN_HEIGHT) = 19, framebuffer address width.

Ports:
- iClk  in  1  clock.
- iResetn  in  1  reset.
- iX_pixel  in  $clog2(SCREEN_WIDTH)+1  plot x coordinate.
- iY_pixel  in  $clog2(SCREEN_HEIGHT)+1  plot y coordinate.
- iColour  in  COLOUR_W  plot colour.
- iPlot  in  1  plot strobe; one pixel per cycle while high.
- iMemGrant  in  1  framebuffer accepts the presented write this cycle.
- iClearErr  in  1  clears sticky error flags.
- oMemAddr  out  ADDR_W  write address (FIFO head).
- oMemData  out  COLOUR_W  write data (FIFO head).
- oMemWe  out  1  write request; high while FIFO not empty.
- oBusy  out  1  any pipeline stage valid or FIFO not empty.
- oClipped  out  1  one-cycle pulse when an out-of-range plot is discarded.
- oOverflow  out  1  sticky; a write was dropped because the FIFO was full.

Behaviour:
- Reset: iResetn asynchronous, active-low; clock iClk.
- Reset values:
  - Pipeline valids 0; FIFO empty, pointers 0.
  - oMemWe=0, oMemAddr=0, oMemData=0, oBusy=0, oClipped=0, oOverflow=0.
  - Reset mid-operation discards all pending writes; nothing partial reaches memory after reset asserts.
- Stage 1, capture: at each edge with iPlot=1, register x, y, colour and valid=1. valid=0 otherwise.
- Stage 2, clip and address, applied to the stage-1 contents:
  - If x ≥ SCREEN_WIDTH or y ≥ SCREEN_HEIGHT: drop the entry and pulse oClipped=1 on the following cycle.
  - Else: register addr = y*SCREEN_WIDTH + x, computed at full ADDR_W width with no truncation before the add, plus colour and valid.
- Stage 3, FIFO push: a valid stage-2 entry is pushed at the next edge.
- Latency: a plot sampled at edge E0 is visible on oMemWe/oMemAddr/oMemData right after edge E2 when the FIFO is empty.
- Pipeline never stalls; it accepts one plot per cycle indefinitely.
- Memory handshake:
  - oMemWe = FIFO not empty; oMemAddr/oMemData = head entry.
  - A transfer occurs on an edge where oMemWe && iMemGrant; the head is popped at that edge.
  - Head outputs hold stable while oMemWe=1 and iMemGrant=0.
- Ordering: strictly FIFO; writes reach memory in plot order.
- Boundary conditions:
  - Full with push and no pop: the incoming entry is dropped; oOverflow set at that edge. The FIFO content is unchanged.
  - Full with simultaneous push and pop: both occur, nothing is dropped, count unchanged.
  - Empty with push: the entry becomes head at that edge; no same-cycle bypass.
  - Pointers wrap modulo FIFO_DEPTH; count runs 0..FIFO_DEPTH.
- oOverflow clears on iClearErr=1. If a set event occurs in the same cycle as iClearErr, the set wins.
- oBusy = stage1.valid | stage2.valid | !empty, combinational. The drawing FSM waits for oBusy=0 before leaving CLEAR.

Optional Feature:
- Macro PLOT_SINK_STATS_EN.
- Defined:
  - Adds outputs oWriteCount[31:0], incremented per completed memory transfer.
  - Adds oDropCount[15:0], incremented per overflow drop and per clip; saturates at 0xFFFF.
  - Both counters reset to 0 on iResetn and on iClearErr.
- Undefined: ports and counters are absent; all other behaviour is identical.

Decomposition:
- Shared package draw_pkg:
  - SCREEN_WIDTH/HEIGHT defaults, COLOUR_W.
  - Colour constants COL_BLACK=3'b000, COL_WHITE=3'b111.
  - ADDR_W function, and a typedef for the pixel write entry {addr, colour}.
- One sub-module, plot_fifo: synchronous FIFO, parameterised width and depth. Provides push/pop/full/empty and head outputs; full-and-pop push allowed.

Test Plan:
- iPlot one cycle with x=5, y=3, colour=6, iMemGrant=1 -> after E2 oMemWe=1, oMemAddr=1925, oMemData=6; transfer on the next edge, then oBusy=0.
- Plot (639,479,colour 7) -> oMemAddr=307199. Plot (640,0) -> no write, oClipped one-cycle pulse.
- iMemGrant=0, 10 consecutive plots at x=0..9, y=0 -> FIFO holds addr 0..3, oOverflow=1, drop count 6 (stats on). Then iMemGrant=1 -> exactly 4 writes, addresses 0,1,2,3, in order.
- FIFO full, iMemGrant=1 with continuous plots -> one write per cycle, no drops, oOverflow stays 0.
- iResetn low while FIFO holds 3 entries and iPlot active -> all outputs 0 immediately. After release, no stale write appears; the next plot appears after E2.
- iClearErr with oOverflow=1 and no overflow event -> oOverflow=0 the next cycle. iClearErr coinciding with an overflow drop -> oOverflow remains 1.
